// File: rtl/dm_arbiter.sv
// dm_arbiter: arbitrates the single-port data memory between the CPU datapath and an
// external loader/debug port using fixed 3-cycle transactions. Rev 1.0
`default_nettype none

module dm_arbiter #(
  parameter int AW           = 16,
  parameter int DW           = 32,
  parameter int EXT_MAX_HOLD = 4
) (
  input  logic          clk,
  input  logic          rst_f,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          ext_req,
  input  logic          ext_we,
  input  logic          ext_lock,
  input  logic [AW-1:0] ext_addr,
  input  logic [DW-1:0] ext_wdata,
  output logic          ext_ack,
  output logic [DW-1:0] ext_rdata,
  output logic [AW-1:0] dm_addr,
  output logic [DW-1:0] dm_wdata,
  output logic          dm_we,
  input  logic [DW-1:0] dm_rdata,
  output logic          busy
);

  localparam int HW = $clog2(EXT_MAX_HOLD + 1);
  localparam logic GRANT_CPU = 1'b0;
  localparam logic GRANT_EXT = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GNT_CPU = 2'd1,
    S_GNT_EXT = 2'd2,
    S_ACK     = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          we_q, we_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] ext_rdata_q, ext_rdata_d;
  logic          pick_ext;

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_q     <= S_IDLE;
      last_q      <= GRANT_EXT;
      hold_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      cpu_rdata_q <= '0;
      ext_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      hold_q      <= hold_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      cpu_rdata_q <= cpu_rdata_d;
      ext_rdata_q <= ext_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    hold_d      = hold_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    ext_rdata_d = ext_rdata_q;
    pick_ext    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cpu_req || ext_req) begin
          if (!cpu_req) begin
            pick_ext = 1'b1;
          end else if (!ext_req) begin
            pick_ext = 1'b0;
          end else if (ext_lock && (last_q == GRANT_EXT) && (hold_q < HW'(EXT_MAX_HOLD))) begin
            pick_ext = 1'b1;
          end else begin
            pick_ext = (last_q == GRANT_CPU);
          end
          if (pick_ext) begin
            state_d = S_GNT_EXT;
            addr_d  = ext_addr;
            wdata_d = ext_wdata;
            we_d    = ext_we;
            // A contested EXT grant after an EXT grant can only be the locked branch.
            if (!cpu_req) begin
              hold_d = '0;
            end else if (last_q == GRANT_EXT) begin
              hold_d = hold_q + HW'(1);
            end
          end else begin
            state_d = S_GNT_CPU;
            addr_d  = cpu_addr;
            wdata_d = cpu_wdata;
            we_d    = cpu_we;
            hold_d  = '0;
          end
        end
      end
      S_GNT_CPU: begin
        if (!we_q) cpu_rdata_d = dm_rdata;
        last_d  = GRANT_CPU;
        state_d = S_ACK;
      end
      S_GNT_EXT: begin
        if (!we_q) ext_rdata_d = dm_rdata;
        last_d  = GRANT_EXT;
        state_d = S_ACK;
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // last_q already names the owner of the transaction being acknowledged.
  assign cpu_ack   = (state_q == S_ACK) && (last_q == GRANT_CPU);
  assign ext_ack   = (state_q == S_ACK) && (last_q == GRANT_EXT);
  assign cpu_stall = cpu_req & ~cpu_ack;
  assign cpu_rdata = cpu_rdata_q;
  assign ext_rdata = ext_rdata_q;
  assign dm_addr   = addr_q;
  assign dm_wdata  = wdata_q;
  assign dm_we     = we_q;
  assign busy      = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: table-driven vectors plus an ack scoreboard for dm_arbiter. Rev 1.0
`default_nettype none

module tb_dm_arbiter;
  localparam int AW = 16;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_f = 1'b0;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          ext_req = 1'b0, ext_we = 1'b0, ext_lock = 1'b0;
  logic [AW-1:0] ext_addr = '0;
  logic [DW-1:0] ext_wdata = '0;
  logic          cpu_ack, cpu_stall, ext_ack, dm_we, busy;
  logic [DW-1:0] cpu_rdata, ext_rdata, dm_wdata, dm_rdata;
  logic [AW-1:0] dm_addr;

  dm_arbiter #(.AW(AW), .DW(DW), .EXT_MAX_HOLD(4)) dut (
    .clk(clk), .rst_f(rst_f),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_lock(ext_lock), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_ack(ext_ack), .ext_rdata(ext_rdata),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_we(dm_we), .dm_rdata(dm_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:255];
  assign dm_rdata = mem[dm_addr[7:0]];
  always @(posedge clk) if (dm_we) mem[dm_addr[7:0]] <= dm_wdata;

  typedef struct {
    bit            ext;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  typedef struct {
    bit            ext;
    bit            rd;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[8];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push(input bit ext, input bit rd, input logic [DW-1:0] d);
    exp_t e;
    e.ext = ext; e.rd = rd; e.rdata = d;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (cpu_ack || ext_ack) begin
      chk("ack_overlap", {63'd0, cpu_ack & ext_ack}, 64'd0);
      chk("we_in_ack", {63'd0, dm_we}, 64'd0);
      if (sb.size() == 0) begin
        chk("unexpected_ack", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("ack_owner", {63'd0, ext_ack}, {63'd0, mon_e.ext});
        if (mon_e.rd) chk("rdata", mon_e.ext ? ext_rdata : cpu_rdata, mon_e.rdata);
      end
    end
  end

  task automatic do_txn(input vec_t v, input string nm);
    bit seen = 1'b0;
    int wecnt = 0;
    @(posedge clk); #1;
    if (v.ext) begin
      ext_req = 1'b1; ext_we = v.we; ext_addr = v.addr; ext_wdata = v.wdata;
    end else begin
      cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
    end
    push(v.ext, !v.we, v.exp_rdata);
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      if (dm_we) begin
        wecnt++;
        chk({nm, "_waddr"}, dm_addr, v.addr);
        chk({nm, "_wdata"}, dm_wdata, v.wdata);
      end
      if (!v.ext) chk({nm, "_stall"}, cpu_stall, (i == 2) ? 64'd0 : 64'd1);
      if (v.ext ? ext_ack : cpu_ack) begin
        seen = 1'b1;
        chk({nm, "_lat"}, i, 2);
      end
    end
    chk({nm, "_acked"}, seen, 1);
    chk({nm, "_wecnt"}, wecnt, v.we);
    @(posedge clk); #1;
    cpu_req = 1'b0; ext_req = 1'b0;
  endtask

  task automatic run_held(input int n, input string nm);
    int got = 0;
    int last_t = 0;
    for (int i = 0; i < n * 3 + 6 && got < n; i++) begin
      @(negedge clk);
      if (cpu_ack || ext_ack) begin
        if (got > 0) chk({nm, "_spacing"}, cyc - last_t, 3);
        last_t = cyc;
        got++;
      end
    end
    chk({nm, "_count"}, got, n);
    @(posedge clk); #1;
    cpu_req = 1'b0; ext_req = 1'b0; ext_lock = 1'b0;
    chk({nm, "_sb_empty"}, sb.size(), 0);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_dm_we"}, dm_we, 0);
    chk({nm, "_dm_addr"}, dm_addr, 0);
    chk({nm, "_dm_wdata"}, dm_wdata, 0);
    chk({nm, "_acks"}, {cpu_ack, ext_ack}, 0);
    chk({nm, "_rdata"}, {cpu_rdata, ext_rdata}, 0);
    chk({nm, "_busy"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE0000 | i;
    vecs[0] = '{1'b0, 1'b1, 16'h0010, 32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b0, 1'b0, 16'h0010, 32'h0,        32'hDEADBEEF};
    vecs[2] = '{1'b1, 1'b1, 16'h0020, 32'h12345678, 32'h0};
    vecs[3] = '{1'b1, 1'b0, 16'h0020, 32'h0,        32'h12345678};
    vecs[4] = '{1'b1, 1'b0, 16'h0010, 32'h0,        32'hDEADBEEF};
    vecs[5] = '{1'b0, 1'b0, 16'h0020, 32'h0,        32'h12345678};
    vecs[6] = '{1'b0, 1'b1, 16'h00FF, 32'hA5A55A5A, 32'h0};
    vecs[7] = '{1'b1, 1'b0, 16'h00FF, 32'h0,        32'hA5A55A5A};

    // Reset held with both requesters active; CPU must win the first tie.
    cpu_req = 1'b1; cpu_addr = 16'h0030;
    ext_req = 1'b1; ext_addr = 16'h0040;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk); #1;
    rst_f = 1'b1;
    push(1'b0, 1'b1, 32'hC0DE0030);
    push(1'b1, 1'b1, 32'hC0DE0040);
    run_held(2, "first_tie");

    @(posedge clk); #1;
    cpu_req = 1'b1; ext_req = 1'b1;
    push(1'b0, 1'b1, 32'hC0DE0030);
    push(1'b1, 1'b1, 32'hC0DE0040);
    push(1'b0, 1'b1, 32'hC0DE0030);
    push(1'b1, 1'b1, 32'hC0DE0040);
    run_held(4, "round_robin");

    for (int k = 0; k < 8; k++) begin
      do_txn(vecs[k], $sformatf("vec%0d", k));
      if (k == 2) begin
        chk("cpu_rdata_hold", cpu_rdata, 32'hDEADBEEF);
        chk("ext_rdata_after_write", ext_rdata, 32'hC0DE0040);
      end
    end

    // Lock cap: last grant EXT, then 4 locked EXT grants, one CPU, then EXT again.
    do_txn('{1'b1, 1'b0, 16'h0040, 32'h0, 32'hC0DE0040}, "lock_pre");
    @(posedge clk); #1;
    cpu_we = 1'b0; cpu_addr = 16'h0030; ext_we = 1'b0; ext_addr = 16'h0040;
    cpu_req = 1'b1; ext_req = 1'b1; ext_lock = 1'b1;
    for (int k = 0; k < 4; k++) push(1'b1, 1'b1, 32'hC0DE0040);
    push(1'b0, 1'b1, 32'hC0DE0030);
    push(1'b1, 1'b1, 32'hC0DE0040);
    run_held(6, "lock_cap");

    // CPU drops its request right after the grant edge.
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0020;
    push(1'b0, 1'b1, 32'h12345678);
    @(negedge clk);
    chk("drop_stall_pending", cpu_stall, 1);
    @(negedge clk);
    chk("drop_busy_gnt", busy, 1);
    cpu_req = 1'b0;
    #1 chk("drop_stall_released", cpu_stall, 0);
    @(negedge clk);
    chk("drop_ack", cpu_ack, 1);
    chk("drop_stall_ack", cpu_stall, 0);
    @(negedge clk);
    chk("drop_idle", {busy, cpu_ack}, 0);
    chk("drop_sb_empty", sb.size(), 0);

    // Reset during an EXT write grant aborts it.
    @(posedge clk); #1;
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 16'h0050; ext_wdata = 32'hBAD0BAD0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_we_before", dm_we, 1);
    #1 rst_f = 1'b0;
    #1 chk("abort_we_async", dm_we, 0);
    chk("abort_busy", busy, 0);
    ext_we = 1'b0; ext_addr = 16'h0040;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0030;
    repeat (2) @(negedge clk);
    chk_reset_outputs("abort_reset");
    chk("abort_mem_untouched", mem[8'h50], 32'hC0DE0050);
    @(posedge clk); #1;
    rst_f = 1'b1;
    push(1'b0, 1'b1, 32'hC0DE0030);
    push(1'b1, 1'b1, 32'hC0DE0040);
    run_held(2, "after_abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Arbitrates the single-port data memory (dm) between two requesters: the SISC CPU datapath (load/store) and an external loader/debug port (program/data preload, memory dump).
- Sits between the datapath's address mux/register file and dm, and drives dm's address, write-data and write-enable.
- Uses a registered FSM with fixed 3-cycle transactions, round-robin fairness and a bounded external lock. Exposes a stall to the controller while a CPU request is pending.

Parameters:
AW, 16, address width (matches dm address)
DW, 32, data width (matches register file and dm word)
EXT_MAX_HOLD, 4, max consecutive locked ext grants while cpu_req is pending

Ports:
clk  in  1  system clock, rising edge
rst_f  in  1  asynchronous, active-low reset
cpu_req  in  1  CPU access request, held until cpu_ack
cpu_we  in  1  1=store, 0=load
cpu_addr  in  AW  CPU address
cpu_wdata  in  DW  CPU store data
cpu_ack  out  1  one-cycle completion pulse
cpu_rdata  out  DW  registered load data
cpu_stall  out  1  cpu_req & ~cpu_ack (combinational), to controller
ext_req  in  1  external request, held until ext_ack
ext_we  in  1  1=write, 0=read
ext_lock  in  1  request back-to-back priority for burst
ext_addr  in  AW  external address
ext_wdata  in  DW  external write data
ext_ack  out  1  one-cycle completion pulse
ext_rdata  out  DW  registered read data
dm_addr  out  AW  memory address (registered)
dm_wdata  out  DW  memory write data (registered)
dm_we  out  1  memory write enable (registered)
dm_rdata  in  DW  memory read data (combinational read)
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst_f=0, asynchronous): state=IDLE; dm_we=0, dm_addr=0, dm_wdata=0; cpu_ack=ext_ack=0; cpu_rdata=ext_rdata=0; last_grant=EXT (CPU wins the first tie); hold_cnt=0; busy=0. Reset mid-transaction aborts it: no ack and no further write.
- States: IDLE, GNT_CPU, GNT_EXT, ACK.
- IDLE: samples the requests at the clock edge. If any request is present, latch the winner's addr/wdata/we into dm_addr/dm_wdata/dm_we and go to GNT_CPU or GNT_EXT. If none is present, stay; dm_we=0 and dm_addr/dm_wdata hold their last values.
- Arbitration in IDLE, in priority order:
  - Only one request: grant it.
  - Both requests, ext_lock=1, last_grant=EXT, hold_cnt<EXT_MAX_HOLD: grant EXT, hold_cnt++.
  - Both requests otherwise: grant the requester opposite to last_grant.
- hold_cnt behaviour:
  - Resets to 0 on any CPU grant, or whenever an EXT grant occurs with cpu_req=0.
  - When hold_cnt reaches EXT_MAX_HOLD with cpu_req pending, the next tie goes to CPU.
- GNT_x (exactly 1 cycle):
  - dm_* are driven from registers; dm_we=1 for this single cycle if it is a write.
  - At the end of the cycle, on a read, dm_rdata is captured into x_rdata. On a write, x_rdata is unchanged.
  - last_grant is set to x; go to ACK and clear dm_we.
- ACK (1 cycle): x_ack=1 for exactly this cycle; requests are ignored; go to IDLE.
- Latency: request sampled at edge N → ack high in cycle N+2 → next sample at edge N+3. Throughput is 1 transaction per 3 cycles.
- Read data is valid in the ack cycle and held until the next read by the same requester.
- A requester dropping req after being granted does not cancel the transaction; the access still completes and ack still pulses.
- A requester must not change addr/we/wdata between req assertion and ack. Only the values at the grant edge are used.
- cpu_ack and ext_ack are never high in the same cycle. dm_we is never high outside GNT_*.
- Address and data pass through unmodified, with no width conversion.

Test Plan:
- Reset: hold rst_f=0 with both reqs high → all outputs 0, busy=0. Release reset → CPU granted first (cpu_ack at cycle +2, ext waits).
- CPU store then load: cpu store addr=0x0010, wdata=0xDEADBEEF → dm_we=1 for exactly one cycle with dm_addr=0x0010, cpu_ack 1 cycle later. Then load 0x0010 with the dm model returning 0xDEADBEEF → cpu_rdata=0xDEADBEEF when cpu_ack=1.
- Round-robin: both reqs held continuously, ext_lock=0 → grant order CPU, EXT, CPU, EXT. Acks alternate every 3 cycles and never overlap.
- Lock cap: ext_lock=1, EXT_MAX_HOLD=4, both reqs held, last grant EXT → exactly 4 more ext_acks, then a cpu_ack, then EXT resumes.
- Abort on reset: assert rst_f=0 during a GNT_EXT write → dm_we falls immediately (asynchronously), no ext_ack. After release, state is IDLE and the next sample behaves as after a fresh reset.
- Drop req: cpu_req deasserted the cycle after the grant edge → cpu_ack still pulses once, then IDLE. cpu_stall=cpu_req&~cpu_ack throughout.
